uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
UART receive controller. It oversamples the serial line, frames 8N1 characters and stores each good byte in a two-slot ping-pong buffer. It drives `data0`, `data1` and `sel` into the 2:1 byte mux `uart_rx_mux_1`, so the mux output always shows the oldest unread byte. Downstream logic reads that mux output under a valid/ready handshake.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200 baud); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the mid-start-bit sample point (integer division).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_i  in  1  serial line; asynchronous to clk, idles high
- data0  out  8  buffer slot 0, feeds uart_rx_mux_1.data0
- data1  out  8  buffer slot 1, feeds uart_rx_mux_1.data1
- sel  out  1  read pointer (slot of oldest unread byte), feeds uart_rx_mux_1.sel
- rx_valid  out  1  at least one unread byte is buffered
- rx_ready  in  1  consumer accepts the byte on the mux output this cycle
- frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
- overrun  out  1  one-cycle pulse: good byte received while buffer full, byte discarded

Behaviour:
- One clock, synchronous active-high reset, as already decided.
- Reset values:
  - data0, data1, sel, rx_valid, frame_err, overrun = 0.
  - Internal write pointer = 0, byte count = 0, shift reg = 0, baud counter = 0, bit index = 0.
  - Both synchronizer flops = 1; FSM = IDLE.
- Synchronizer: rx_i passes through 2 flops; all sampling uses the second flop (rx_s).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s==0 -> START, baud counter cleared.
  - START: count to HALF_BIT-1. At that point rx_s==0 -> DATA (counter and bit index cleared). rx_s==1 -> IDLE (glitch rejected, no flags).
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift reg, LSB first (shift right, new bit into bit 7). After the 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s==1: issue a write request; -> IDLE.
    - rx_s==0: pulse frame_err for 1 cycle, no write; -> IDLE.
  - Returning to IDLE at mid stop bit lets the next start edge be caught.
- Buffer (count 0..2):
  - Write request with count<2: byte -> slot[wr_ptr]; wr_ptr toggles; count +1.
  - Write request with count==2 and no consume that cycle: overrun pulses for 1 cycle; slots, count and pointers unchanged.
  - Consume (rx_valid && rx_ready): sel toggles; count -1; the slot content is not cleared.
  - Write and consume in the same cycle: both take effect. Count unchanged, no overrun even at count==2, because the consumed slot is the one being written.
  - rx_ready while rx_valid==0 is ignored.
- rx_valid = (count != 0), registered.
- Latency: rx_valid and the slot data update on the cycle after the stop-sample cycle. Frame start to rx_valid is ~ HALF_BIT + 9*CLKS_PER_BIT + 4 cycles, including 2 synchronizer cycles.
- frame_err and overrun never assert in the same cycle; only one write request exists per frame.
- Reset mid-frame: the frame is abandoned and the buffer emptied. If the line is low when reset deasserts, a spurious START may follow. It either resolves as a framing error or is rejected in START; no lockup.

Test Plan (CLKS_PER_BIT=8, bit driven for exactly 8 clks, mux instantiated on outputs):
1. Frame 0xA5, stop=1 -> rx_valid rises; data0=0xA5, sel=0, mux out=0xA5. One-cycle rx_ready -> rx_valid=0, sel=1, no flags.
2. Frames 0x3C then 0xC3, rx_ready=0 -> count 2, data0=0x3C, data1=0xC3, sel=0. Ready pulse -> mux out=0xC3, sel=1. Second ready pulse -> rx_valid=0, sel=0.
3. Buffer full (test 2 state), then frame 0x55 -> overrun pulses exactly 1 cycle; data0/data1 unchanged. Repeat with rx_ready high on the write cycle -> 0x55 lands in slot 0, no overrun.
4. Frame 0xFF with stop bit 0 -> frame_err pulses 1 cycle; rx_valid stays 0; next frame 0x12 received correctly.
5. rx_i low for 2 clks, then high -> START rejects it, returns to IDLE; no rx_valid and no flags for 200 clks.
6. rst high for 1 cycle during data bit 3 of a frame, line released high -> all outputs 0. Next frame 0x81 gives rx_valid with mux out=0x81.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: oversampled framing into a two-slot ping-pong buffer
// whose slots and read pointer feed an external 2:1 byte mux.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data0,
  output logic [7:0] data1,
  output logic       sel,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          wr_ptr;
  logic [1:0]    count;
  logic [1:0]    count_n;
  logic          stop_sample;
  logic          wr_req;
  logic          bad_stop;
  logic          consume;
  logic          do_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // A full buffer still accepts a write when the same cycle consumes,
  // because the slot being read is exactly the slot being overwritten.
  always_comb begin
    stop_sample = (state == STOP) && (baud_cnt == BIT_LAST);
    wr_req      = stop_sample && rx_s;
    bad_stop    = stop_sample && !rx_s;
    consume     = rx_valid && rx_ready;
    do_write    = wr_req && ((count != 2'd2) || consume);
    count_n     = count;
    if (do_write && !consume)
      count_n = count + 2'd1;
    else if (!do_write && consume)
      count_n = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data0     <= '0;
      data1     <= '0;
      sel       <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= wr_req && !do_write;
      if (do_write) begin
        if (wr_ptr)
          data1 <= shift;
        else
          data0 <= shift;
        wr_ptr <= ~wr_ptr;
      end
      if (consume)
        sel <= ~sel;
      count    <= count_n;
      rx_valid <= (count_n != 2'd0);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: serial frames in, scoreboard of expected
// bytes checked against the 2:1 mux output at each consume.
module tb_uart_rx_ctrl;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic       rx_ready;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       sel;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [7:0] mux_out;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, valid_cnt = 0;
  int fe0, ov0, vc0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (rx_i),
    .data0    (data0),
    .data1    (data1),
    .sel      (sel),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // uart_rx_mux_1 behaviour on the buffer outputs
  assign mux_out = sel ? data1 : data0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
    if (rx_valid === 1'b1) valid_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_bit(input logic v);
    rx_i = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    @(posedge clk);
    #1;
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit(stopb);
    rx_i = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, rx_valid}, 32'd1);
  endtask

  task automatic consume(input string tag);
    logic [7:0] e;
    @(negedge clk);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    chk({tag, "_mux"}, {24'd0, mux_out}, {24'd0, e});
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_data0"}, {24'd0, data0}, 32'd0);
    chk({tag, "_data1"}, {24'd0, data1}, 32'd0);
    chk({tag, "_sel"}, {31'd0, sel}, 32'd0);
    chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_i     = 1'b1;
    rx_ready = 1'b0;
    do_reset();
    chk_outputs_zero("reset");

    // 1: single byte, single consume
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    wait_valid("t1_wait");
    @(negedge clk);
    chk("t1_data0", {24'd0, data0}, 32'hA5);
    chk("t1_sel", {31'd0, sel}, 32'd0);
    consume("t1_c");
    @(negedge clk);
    chk("t1_valid_after", {31'd0, rx_valid}, 32'd0);
    chk("t1_sel_after", {31'd0, sel}, 32'd1);
    chk("t1_flags", fe_cnt + ov_cnt, 32'd0);

    // 2: fill both slots, then drain in order
    do_reset();
    send_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    send_frame(8'hC3, 1'b1);
    exp_q.push_back(8'hC3);
    wait_valid("t2_wait");
    repeat (4) @(negedge clk);
    chk("t2_data0", {24'd0, data0}, 32'h3C);
    chk("t2_data1", {24'd0, data1}, 32'hC3);
    chk("t2_sel", {31'd0, sel}, 32'd0);
    consume("t2_c0");
    @(negedge clk);
    chk("t2_mux_next", {24'd0, mux_out}, 32'hC3);
    chk("t2_sel_next", {31'd0, sel}, 32'd1);
    consume("t2_c1");
    @(negedge clk);
    chk("t2_valid_empty", {31'd0, rx_valid}, 32'd0);
    chk("t2_sel_empty", {31'd0, sel}, 32'd0);

    // 3: overrun on full buffer, then write coinciding with consume
    send_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    send_frame(8'hC3, 1'b1);
    exp_q.push_back(8'hC3);
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    chk("t3_ovr_pulse", ov_cnt - ov0, 32'd1);
    chk("t3_data0_keep", {24'd0, data0}, 32'h3C);
    chk("t3_data1_keep", {24'd0, data1}, 32'hC3);
    ov0 = ov_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (78) @(posedge clk);
        #2;
        chk("t3_mux_pre", {24'd0, mux_out}, {24'd0, exp_q.pop_front()});
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    exp_q.push_back(8'h55);
    repeat (4) @(negedge clk);
    chk("t3_no_ovr", ov_cnt - ov0, 32'd0);
    chk("t3_data0_new", {24'd0, data0}, 32'h55);
    chk("t3_data1_same", {24'd0, data1}, 32'hC3);
    chk("t3_sel", {31'd0, sel}, 32'd1);
    consume("t3_c0");
    consume("t3_c1");
    @(negedge clk);
    chk("t3_empty", {31'd0, rx_valid}, 32'd0);

    // 4: framing error, then a good frame
    fe0 = fe_cnt;
    vc0 = valid_cnt;
    send_frame(8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4_ferr_pulse", fe_cnt - fe0, 32'd1);
    chk("t4_no_valid", valid_cnt - vc0, 32'd0);
    send_frame(8'h12, 1'b1);
    exp_q.push_back(8'h12);
    wait_valid("t4_wait");
    consume("t4_c");

    // 5: short glitch rejected in START
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vc0 = valid_cnt;
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (200) @(posedge clk);
    chk("t5_no_valid", valid_cnt - vc0, 32'd0);
    chk("t5_no_ferr", fe_cnt - fe0, 32'd0);
    chk("t5_no_ovr", ov_cnt - ov0, 32'd0);

    // 6: reset during data bit 3 with a byte already buffered
    send_frame(8'h77, 1'b1);
    wait_valid("t6_pre");
    @(posedge clk);
    #1;
    put_bit(1'b0);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    rx_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst  = 1'b1;
    rx_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk_outputs_zero("t6_rst");
    repeat (20) @(posedge clk);
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    wait_valid("t6_wait");
    consume("t6_c");

    chk("never_both_flags", both_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
